// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the direct-mapped cache.
// The granted request is latched so the cache sees a stable address across write-back and refill.
module cache_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic                  cache_mem_en,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_din,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_dout,

    input  logic                  stat_clr,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  access_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  last_grant;
    logic                  gnt;
    logic                  first;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_din;

    logic                  grant_valid;
    logic                  grant_port;
    logic                  busy_hit;
    logic                  busy_first_miss;

    // Tie goes to the port that did not win last time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else if (req1) begin
            grant_port = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = BUSY;
            BUSY:    if (cache_hit)   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_hit        = (state == BUSY) && cache_hit;
    assign busy_first_miss = (state == BUSY) && first && !cache_hit;

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            first      <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_din    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt      <= grant_port;
                        first    <= 1'b1;
                        req_we   <= grant_port ? we1   : we0;
                        req_addr <= grant_port ? addr1 : addr0;
                        req_din  <= grant_port ? din1  : din0;
                    end
                end
                BUSY: begin
                    first <= 1'b0;
                    if (cache_hit) begin
                        last_grant <= gnt;
                    end
                end
                default: ;
            endcase
        end
    end

    // ack is raised on the hit edge so it is high exactly during RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= busy_hit && !gnt;
            ack1 <= busy_hit &&  gnt;
            if (busy_hit && !req_we) begin
                if (gnt) begin
                    rdata1 <= cache_dout;
                end else begin
                    rdata0 <= cache_dout;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else if (stat_clr) begin
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if ((state == RESP) && (access_cnt != CNT_MAX)) begin
                access_cnt <= access_cnt + 1'b1;
            end
            if (busy_first_miss && (miss_cnt != CNT_MAX)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    assign cache_mem_en = (state == BUSY);
    assign cache_we     = (state == BUSY) && req_we;
    assign cache_addr   = req_addr;
    assign cache_din    = req_din;
    assign busy         = (state != IDLE);

endmodule
